// File: rtl/sram_nobl_ctrl.sv
// -----------------------------------------------------------------------------
// sram_nobl_ctrl
//
// Command controller for a 512K x 36 NoBL pipelined SRAM. It accepts 1-4 beat
// read/write requests over a valid/ready handshake and drives the synchronous
// SRAM pins. Beat 0 is a load cycle and later beats are advance cycles. Write
// data goes out two clocks behind its address. Read data comes back three clocks
// after the beat was issued.
//
// Optional feature: define SRAM_PARITY_EN to generate even parity in bit 8 of
// each 9-bit lane on writes and check it on reads. With the macro undefined,
// data passes through unchanged and rd_par_err is held at 0.
//
// Ports
//   clk, reset                 clock (also the SRAM clock); sync active-high reset
//   req_vld/req_rdy            request handshake (req_rdy high only in IDLE)
//   req_wr, req_addr,          request: direction, start word address,
//   req_len, req_be              beats-1, byte-lane enables (writes only)
//   wr_data_pop, wr_data       write beat must be presented while pop is high
//   rd_vld, rd_data,           one read beat per rd_vld cycle, plus the
//   rd_par_err                   per-lane parity error flags
//   sram_*                     SRAM pins; sram_tri_en=1 means the controller
//                                drives the pad, sram_rd_data is the pad input
// -----------------------------------------------------------------------------
module sram_nobl_ctrl #(
   parameter int ADDR_WIDTH = 19,
   parameter int DATA_WIDTH = 36
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_vld,
   output logic                  req_rdy,
   input  logic                  req_wr,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [1:0]            req_len,
   input  logic [3:0]            req_be,
   output logic                  wr_data_pop,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  rd_vld,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic [3:0]            rd_par_err,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   output logic                  sram_ce_n,
   output logic                  sram_adv_ld_n,
   output logic                  sram_we_n,
   output logic [3:0]            sram_bw_n,
   output logic                  sram_oe_n,
   output logic [DATA_WIDTH-1:0] sram_wr_data,
   output logic                  sram_tri_en,
   input  logic [DATA_WIDTH-1:0] sram_rd_data
);

   localparam int LW     = DATA_WIDTH / 4;  // byte-lane width (9 bits)
   localparam int STAGES = 3;

   typedef enum logic {IDLE, BURST} state_t;

   state_t      state;
   logic [1:0]  beat_cnt;

   // Beat tags, shifted every cycle regardless of state. Bit j is set j clocks
   // after the beat was on the pins:
   //   wr_pipe[1] -> pop the write beat now, wr_pipe[2] -> data on the pad
   //   rd_pipe[2] -> pad data is captured at the next edge
   logic [STAGES-1:0] wr_pipe;
   logic [STAGES-1:0] rd_pipe;

   logic issue, issue_wr;
   logic [DATA_WIDTH-1:0] wr_word;
   logic [3:0]            rd_err;

   assign req_rdy     = (state == IDLE);
   assign issue       = (state == BURST) || req_vld;
   // During a burst, the direction is the one latched on the load cycle.
   assign issue_wr    = (state == BURST) ? ~sram_we_n : req_wr;
   assign wr_data_pop = wr_pipe[1];
   assign sram_tri_en = wr_pipe[2];

`ifdef SRAM_PARITY_EN
   function automatic logic [DATA_WIDTH-1:0] par_gen(input logic [DATA_WIDTH-1:0] d);
      logic [DATA_WIDTH-1:0] r;
      r = d;
      for (int i = 0; i < 4; i++)
         r[i*LW + LW-1] = ^d[i*LW +: LW-1];
      return r;
   endfunction

   // Even parity: a lane's nine bits XOR to zero when it is intact.
   function automatic logic [3:0] par_chk(input logic [DATA_WIDTH-1:0] d);
      logic [3:0] e;
      for (int i = 0; i < 4; i++)
         e[i] = ^d[i*LW +: LW];
      return e;
   endfunction

   assign wr_word = par_gen(wr_data);
   assign rd_err  = par_chk(sram_rd_data);
`else
   assign wr_word = wr_data;
   assign rd_err  = '0;
`endif

   // Command FSM and pin registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         beat_cnt      <= '0;
         sram_addr     <= '0;
         sram_ce_n     <= 1'b1;
         sram_adv_ld_n <= 1'b0;
         sram_we_n     <= 1'b1;
         sram_bw_n     <= 4'hF;
      end else begin
         case (state)
            IDLE: begin
               if (req_vld) begin
                  sram_ce_n     <= 1'b0;
                  sram_adv_ld_n <= 1'b0;
                  sram_addr     <= req_addr;
                  sram_we_n     <= ~req_wr;
                  sram_bw_n     <= req_wr ? ~req_be : 4'hF;
                  beat_cnt      <= req_len;
                  if (req_len != 2'd0) state <= BURST;
               end else begin
                  // deselect
                  sram_ce_n     <= 1'b1;
                  sram_adv_ld_n <= 1'b0;
                  sram_we_n     <= 1'b1;
                  sram_bw_n     <= 4'hF;
               end
            end
            BURST: begin
               // The SRAM steps a[1:0] itself. The address, we_n and bw_n
               // values from the load cycle are held.
               sram_ce_n     <= 1'b0;
               sram_adv_ld_n <= 1'b1;
               beat_cnt      <= beat_cnt - 2'd1;
               if (beat_cnt == 2'd1) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Beat pipelines and data path
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_pipe      <= '0;
         rd_pipe      <= '0;
         sram_oe_n    <= 1'b1;
         sram_wr_data <= '0;
         rd_vld       <= 1'b0;
         rd_data      <= '0;
         rd_par_err   <= '0;
      end else begin
         wr_pipe <= {wr_pipe[STAGES-2:0], issue & issue_wr};
         rd_pipe <= {rd_pipe[STAGES-2:0], issue & ~issue_wr};
         // OE covers the two cycles ahead of each read capture. It is released
         // whenever the pad will be driven next cycle. A write issued one cycle
         // before a read drives the pad one cycle before the read data arrives,
         // so releasing OE here never blocks read data.
         sram_oe_n <= ~(rd_pipe[0] | rd_pipe[1]) | wr_pipe[1];
         if (wr_pipe[1]) sram_wr_data <= wr_word;
         rd_vld     <= rd_pipe[2];
         rd_par_err <= rd_pipe[2] ? rd_err : 4'h0;
         if (rd_pipe[2]) rd_data <= sram_rd_data;
      end
   end

endmodule

// File: tb/tb_sram_nobl_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_nobl_ctrl
//
// Randomized, scoreboarded bench. A behavioural NoBL SRAM drives the pad.
// Expected read data comes from a word-array reference memory that is updated
// when each request is issued. Expected pop and read-valid cycles follow from
// the acceptance cycle. Monitors pop the expectation queues whenever the DUT
// raises wr_data_pop or rd_vld.
// -----------------------------------------------------------------------------
module tb_sram_nobl_ctrl;

   localparam int AW = 19;
   localparam int DW = 36;
`ifdef SRAM_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          req_vld = 1'b0, req_rdy, req_wr = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [1:0]    req_len = '0;
   logic [3:0]    req_be = '0;
   logic          wr_data_pop;
   logic [DW-1:0] wr_data = '0;
   logic          rd_vld;
   logic [DW-1:0] rd_data;
   logic [3:0]    rd_par_err;
   logic [AW-1:0] sram_addr;
   logic          sram_ce_n, sram_adv_ld_n, sram_we_n, sram_oe_n, sram_tri_en;
   logic [3:0]    sram_bw_n;
   logic [DW-1:0] sram_wr_data, sram_rd_data;

   sram_nobl_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .reset(reset),
      .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr),
      .req_addr(req_addr), .req_len(req_len), .req_be(req_be),
      .wr_data_pop(wr_data_pop), .wr_data(wr_data),
      .rd_vld(rd_vld), .rd_data(rd_data), .rd_par_err(rd_par_err),
      .sram_addr(sram_addr), .sram_ce_n(sram_ce_n), .sram_adv_ld_n(sram_adv_ld_n),
      .sram_we_n(sram_we_n), .sram_bw_n(sram_bw_n), .sram_oe_n(sram_oe_n),
      .sram_wr_data(sram_wr_data), .sram_tri_en(sram_tri_en),
      .sram_rd_data(sram_rd_data)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [DW-1:0] rnd36();
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      return t[DW-1:0];
   endfunction

   // ---------------- behavioural NoBL SRAM (1K-word window) ----------------
   typedef struct packed {
      logic          v;
      logic          wr;
      logic [AW-1:0] a;
      logic [3:0]    bw_n;
   } op_t;

   logic [DW-1:0] mem [0:1023];
   op_t           op1, op2;
   logic [AW-1:0] base;
   logic [1:0]    bcnt;
   logic [DW-1:0] rd_out;
   logic          mem_clr = 1'b1;
   logic          poke = 1'b0;
   logic [9:0]    poke_a = '0;

   // The pad shows SRAM data only while OE is asserted.
   assign sram_rd_data = sram_oe_n ? '0 : rd_out;

   always @(posedge clk) begin : sram_model
      logic [AW-1:0] b;
      logic [1:0]    c;
      op_t           cur;
      logic [DW-1:0] nv, rv;
      if (mem_clr) begin
         for (int i = 0; i < 1024; i++) mem[i] <= '0;
         op1 <= '0; op2 <= '0; base <= '0; bcnt <= '0; rd_out <= '0;
      end else begin
         b = base; c = bcnt; cur = '0;
         if (!sram_ce_n) begin
            if (!sram_adv_ld_n) begin b = sram_addr; c = 2'd0; end
            else c = c + 2'd1;
            cur = '{v: 1'b1, wr: !sram_we_n, a: {b[AW-1:2], b[1:0] + c}, bw_n: sram_bw_n};
         end
         base <= b; bcnt <= c;
         // A write sampled two edges ago takes its data from the pad now.
         nv = mem[op2.a[9:0]];
         for (int i = 0; i < 4; i++)
            if (!op2.bw_n[i]) nv[i*9 +: 9] = sram_tri_en ? sram_wr_data[i*9 +: 9] : 9'h0;
         if (op2.v && op2.wr) mem[op2.a[9:0]] <= nv;
         // A read sampled one edge ago drives its data after this edge.
         if (op1.v && !op1.wr)
            rv = (op2.v && op2.wr && op2.a == op1.a) ? nv : mem[op1.a[9:0]];
         else
            rv = rnd36();
         rd_out <= rv;
         op2 <= op1;
         op1 <= cur;
         if (poke) mem[poke_a] <= mem[poke_a] ^ 36'h200;
      end
   end

   // ---------------- reference model + scoreboard ----------------
   logic [DW-1:0] ref_mem [0:1023];

   typedef struct {
      logic [DW-1:0] data;
      logic [3:0]    err;
      int unsigned   due;
   } rexp_t;
   typedef struct {
      logic [DW-1:0] data;
      int unsigned   due;
   } wexp_t;
   rexp_t rq[$];
   wexp_t wq[$];

   function automatic logic [DW-1:0] par_fix(input logic [DW-1:0] d);
      logic [DW-1:0] r;
      r = d;
      if (PAR) for (int i = 0; i < 4; i++) r[i*9 + 8] = ^d[i*9 +: 8];
      return r;
   endfunction

   function automatic logic [3:0] perr(input logic [DW-1:0] d);
      logic [3:0] e;
      e = '0;
      if (PAR) for (int i = 0; i < 4; i++) e[i] = ^d[i*9 +: 9];
      return e;
   endfunction

   // Called at a negedge. Holds the request until the DUT takes it, records the
   // expected effects of every beat, and returns at the negedge after acceptance.
   task automatic send(input logic wr, input logic [AW-1:0] a, input logic [1:0] len,
                       input logic [3:0] be, input logic [DW-1:0] d);
      int            g;
      int unsigned   n;
      logic [AW-1:0] ak;
      logic [DW-1:0] dk, w;
      req_vld = 1'b1; req_wr = wr; req_addr = a; req_len = len; req_be = be;
      g = 0;
      while (!req_rdy && g < 16) begin @(negedge clk); g++; end
      chk("req_rdy_before_accept", 64'(req_rdy), 64'd1);
      if (!req_rdy) begin req_vld = 1'b0; return; end
      n = cyc + 1;
      for (int k = 0; k <= int'(len); k++) begin
         ak = {a[AW-1:2], a[1:0] + 2'(k)};
         if (wr) begin
            dk = d + 36'(k) * 36'h9E3779B9;
            wq.push_back('{data: dk, due: n + 1 + k});
            w = par_fix(dk);
            for (int i = 0; i < 4; i++)
               if (be[i]) ref_mem[ak[9:0]][i*9 +: 9] = w[i*9 +: 9];
         end else begin
            rq.push_back('{data: ref_mem[ak[9:0]], err: perr(ref_mem[ak[9:0]]), due: n + 3 + k});
         end
      end
      @(negedge clk);
      req_vld = 1'b0;
   endtask

   task automatic drain();
      int g;
      g = 0;
      while ((rq.size() != 0 || wq.size() != 0) && g < 200) begin @(negedge clk); g++; end
      chk("drain_rd_queue_empty", 64'(rq.size()), 64'd0);
      chk("drain_wr_queue_empty", 64'(wq.size()), 64'd0);
      repeat (4) @(negedge clk);
   endtask

   // Write-beat monitor: checks pop timing and presents the beat data.
   initial begin : wmon
      wexp_t w;
      forever begin
         @(negedge clk);
         if (wr_data_pop) begin
            if (wq.size() == 0) chk("wr_pop_unexpected", 64'(wr_data_pop), 64'd0);
            else begin
               w = wq.pop_front();
               chk("wr_pop_cycle", 64'(cyc), 64'(w.due));
               wr_data = w.data;
            end
         end else begin
            wr_data = rnd36();
         end
      end
   end

   // Read-beat monitor and bus-contention check.
   initial begin : rmon
      rexp_t r;
      forever begin
         @(negedge clk);
         if (rd_vld) begin
            if (rq.size() == 0) chk("rd_vld_unexpected", 64'(rd_vld), 64'd0);
            else begin
               r = rq.pop_front();
               chk("rd_data", 64'(rd_data), 64'(r.data));
               chk("rd_par_err", 64'(rd_par_err), 64'(r.err));
               chk("rd_vld_cycle", 64'(cyc), 64'(r.due));
            end
         end
         if (sram_tri_en) chk("oe_n_while_driving", 64'(sram_oe_n), 64'd1);
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic chk_idle_pins(input string tag);
      chk({tag, "_req_rdy"},     64'(req_rdy),       64'd1);
      chk({tag, "_ce_n"},        64'(sram_ce_n),     64'd1);
      chk({tag, "_adv_ld_n"},    64'(sram_adv_ld_n), 64'd0);
      chk({tag, "_we_n"},        64'(sram_we_n),     64'd1);
      chk({tag, "_bw_n"},        64'(sram_bw_n),     64'hF);
      chk({tag, "_oe_n"},        64'(sram_oe_n),     64'd1);
      chk({tag, "_tri_en"},      64'(sram_tri_en),   64'd0);
      chk({tag, "_wr_data_pop"}, 64'(wr_data_pop),   64'd0);
      chk({tag, "_rd_vld"},      64'(rd_vld),        64'd0);
      chk({tag, "_rd_par_err"},  64'(rd_par_err),    64'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin : main
      logic [AW-1:0] ra;
      for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
      reset = 1'b1; mem_clr = 1'b1;
      repeat (3) @(negedge clk);
      chk_idle_pins("reset");
      chk("reset_rd_data", 64'(rd_data), 64'd0);
      reset = 1'b0; mem_clr = 1'b0;
      repeat (2) @(negedge clk);

      // Single write then read
      send(1'b1, 19'h00010, 2'd0, 4'hF, 36'h123456789);
      chk("wr_load_ce_n",  64'(sram_ce_n),     64'd0);
      chk("wr_load_adv",   64'(sram_adv_ld_n), 64'd0);
      chk("wr_load_addr",  64'(sram_addr),     64'h10);
      chk("wr_load_we_n",  64'(sram_we_n),     64'd0);
      chk("wr_load_bw_n",  64'(sram_bw_n),     64'h0);
      send(1'b0, 19'h00010, 2'd0, 4'hF, '0);
      chk("rd_load_we_n",  64'(sram_we_n),     64'd1);
      chk("rd_load_bw_n",  64'(sram_bw_n),     64'hF);
      drain();

      // Preload words 4..7, then a 4-beat read from 5 that wraps to 4
      for (int i = 4; i < 8; i++) send(1'b1, 19'(i), 2'd0, 4'hF, 36'(i));
      drain();
      send(1'b0, 19'h00005, 2'd3, 4'hF, '0);
      chk("burst_rdy_low_0", 64'(req_rdy), 64'd0);
      @(negedge clk);
      chk("burst_rdy_low_1", 64'(req_rdy), 64'd0);
      chk("burst_advance",   64'(sram_adv_ld_n), 64'd1);
      chk("burst_addr_held", 64'(sram_addr), 64'h5);
      @(negedge clk);
      chk("burst_rdy_low_2", 64'(req_rdy), 64'd0);
      @(negedge clk);
      chk("burst_rdy_back",  64'(req_rdy), 64'd1);
      drain();

      // Byte-lane write
      send(1'b1, 19'h00040, 2'd0, 4'hF, 36'hFFFFFFFFF);
      send(1'b1, 19'h00040, 2'd0, 4'b0101, 36'h000000000);
      chk("be_write_bw_n", 64'(sram_bw_n), 64'hA);
      send(1'b0, 19'h00040, 2'd0, 4'hF, '0);
      drain();

      // Write / read / write every cycle
      for (int i = 0; i < 6; i++) begin
         ra = (i == 0) ? 19'h00040 : 19'(32'h101 + 2 * (i - 1));
         send(1'b1, 19'(32'h100 + 2 * i), 2'd0, 4'hF, rnd36());
         send(1'b0, ra, 2'd0, 4'hF, '0);
         send(1'b1, 19'(32'h101 + 2 * i), 2'd0, 4'hF, rnd36());
      end
      drain();

`ifdef SRAM_PARITY_EN
      // Corrupt bit 9 (lane 1) of a stored word
      send(1'b1, 19'h00030, 2'd0, 4'hF, rnd36());
      drain();
      poke_a = 10'h030; poke = 1'b1;
      @(negedge clk);
      poke = 1'b0;
      ref_mem[10'h030][9] = ~ref_mem[10'h030][9];
      send(1'b0, 19'h00030, 2'd0, 4'hF, '0);
      drain();
`endif

      // Randomized traffic over a 64-word window
      for (int n = 0; n < 150; n++) begin
         send(1'($urandom_range(0, 1)), 19'(32'h200 + $urandom_range(0, 63)),
              2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), rnd36());
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      drain();

      // Reset during beat 2 of a 4-beat read
      send(1'b0, 19'h00205, 2'd3, 4'hF, '0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      rq.delete();
      wq.delete();
      chk_idle_pins("midreset");
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("post_reset_no_rd_vld", 64'(rd_vld), 64'd0);
      end
      // Controller is usable again after the abort
      send(1'b0, 19'h00205, 2'd1, 4'hF, '0);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
